// File: rtl/alu_pkg.sv
// Shared types and defaults for the two-client shared-ALU arbiter.
// Op and FSM encodings are fixed here so clients and bench agree on them.
package alu_pkg;

    localparam int DATA_W_DEF = 32'd8;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        XOR = 2'b10,
        SHL = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } fsm_state_e;

endpackage

// File: rtl/alu_core8.sv
// Purely combinational ALU: add, subtract, xor, shift-left by one.
// Arithmetic is done one bit wider so the top bit is the carry or borrow.
module alu_core8
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum_s;
    logic [DATA_W:0] diff_s;

    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} - {1'b0, b};

    // Select the result and flag for the requested operation
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            ADD: begin
                result = sum_s[DATA_W-1:0];
                carry  = sum_s[DATA_W];
            end
            SUB: begin
                result = diff_s[DATA_W-1:0];
                carry  = diff_s[DATA_W];
            end
            XOR: begin
                result = a ^ b;
                carry  = 1'b0;
            end
            SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                carry  = a[DATA_W-1];
            end
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter and IDLE/EXEC/RESP sequencer sharing one ALU between
// two clients; result, flag and requester ID are returned on a registered response.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [1:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [1:0]        req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_carry
);

    fsm_state_e        state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    alu_op_e           op_q, op_d;
    logic              id_q, id_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_carry_q, rsp_carry_d;

    logic              grant0_s, grant1_s;
    logic              hs0_s, hs1_s;
    logic [DATA_W-1:0] alu_result_s;
    logic              alu_carry_s;

    alu_core8 #(.DATA_W(DATA_W)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result_s),
        .carry  (alu_carry_s)
    );

    // Round-robin grant, only offered while idle; a tie goes to the client not served last
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0_s = last_grant_q;
                grant1_s = ~last_grant_q;
            end else begin
                grant0_s = req0_valid;
                grant1_s = req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Readies are masked while reset is asserted so nothing is accepted then
    assign req0_ready = rst_n & grant0_s;
    assign req1_ready = rst_n & grant1_s;
    assign hs0_s      = req0_valid & req0_ready;
    assign hs1_s      = req1_valid & req1_ready;

    // Next-state logic for the sequencer, operand latch and response registers
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        case (state_q)
            IDLE: begin
                if (hs0_s || hs1_s) begin
                    state_d      = EXEC;
                    a_d          = hs1_s ? req1_a : req0_a;
                    b_d          = hs1_s ? req1_b : req0_b;
                    op_d         = alu_op_e'(hs1_s ? req1_op : req0_op);
                    id_d         = hs1_s;
                    last_grant_d = hs1_s;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                state_d      = RESP;
                rsp_valid_d  = 1'b1;
                rsp_id_d     = id_q;
                rsp_result_d = alu_result_s;
                rsp_carry_d  = alu_carry_s;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= ADD;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;

endmodule
